// File: rtl/char_normalizer_pkg.sv
// rtl/char_normalizer_pkg.sv - shared types, ASCII constants and classifier for char_normalizer
package char_normalizer_pkg;

   typedef enum logic {
      GAP  = 1'b0,
      WORD = 1'b1
   } norm_state_t;

   typedef enum logic [1:0] {
      CLS_SEP    = 2'd0,
      CLS_LETTER = 2'd1,
      CLS_PRINT  = 2'd2,
      CLS_JUNK   = 2'd3
   } char_class_t;

   localparam logic [7:0] SPACE       = 8'h20;
   localparam logic [7:0] TAB         = 8'h09;
   localparam logic [7:0] LF          = 8'h0A;
   localparam logic [7:0] CR          = 8'h0D;
   localparam logic [7:0] CHAR_A      = 8'h41;
   localparam logic [7:0] CHAR_Z      = 8'h5A;
   localparam logic [7:0] CASE_OFFSET = 8'h20;
   localparam logic [7:0] PRINT_LO    = 8'h21;
   localparam logic [7:0] PRINT_HI    = 8'h7E;

   localparam int DEFAULT_FIFO_DEPTH = 4;

   function automatic char_class_t classify(input logic [7:0] c);
      if (c == SPACE || c == TAB || c == LF || c == CR)
         return CLS_SEP;
      else if (c >= CHAR_A && c <= CHAR_Z)
         return CLS_LETTER;
      else if (c >= PRINT_LO && c <= PRINT_HI)
         return CLS_PRINT;
      else
         return CLS_JUNK;
   endfunction

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - synchronous FIFO with push/pop/full/empty/count; storage is not reset
module char_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/char_normalizer.sv
// rtl/char_normalizer.sv - lowercases letters, drops junk, collapses separator runs to one space, counts words
module char_normalizer
   import char_normalizer_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_char,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_char,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] word_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   norm_state_t     state_q, state_d;
   logic [15:0]     wcnt_q, wcnt_d;
   logic            accept;
   logic            push;
   logic            pop;
   logic [7:0]      push_data;
   logic [7:0]      mapped;
   char_class_t     cls;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   assign in_ready   = (fifo_count < CW'(FIFO_DEPTH));
   assign out_valid  = (fifo_count != '0);
   assign accept     = in_valid & in_ready;
   assign pop        = out_ready & ~fifo_empty;
   assign cls        = classify(in_char);
   assign mapped     = (cls == CLS_LETTER) ? (in_char + CASE_OFFSET) : in_char;
   assign word_count = wcnt_q;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      push      = 1'b0;
      push_data = mapped;
      // cls is only trusted when accept is high, so X on an idle bus is harmless
      if (accept && !fifo_full) begin
         case (state_q)
            GAP: begin
               if (cls == CLS_LETTER || cls == CLS_PRINT) begin
                  push    = 1'b1;
                  state_d = WORD;
                  if (wcnt_q != 16'hFFFF)
                     wcnt_d = wcnt_q + 16'd1;
               end
            end
            WORD: begin
               if (cls == CLS_LETTER || cls == CLS_PRINT) begin
                  push = 1'b1;
               end else if (cls == CLS_SEP) begin
                  push      = 1'b1;
                  push_data = SPACE;
                  state_d   = GAP;
               end
            end
            default: state_d = GAP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= GAP;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (out_char),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_char_normalizer.sv
// tb/tb_char_normalizer.sv - directed self-checking bench for char_normalizer
module tb_char_normalizer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_char;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_char;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] word_count;

   int checks   = 0;
   int failures = 0;
   logic [7:0] outq[$];

   char_normalizer #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_char    (in_char),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_char   (out_char),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // inputs change at posedge+1, so valid&ready seen here means a pop at the next edge
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready)
         outq.push_back(out_char);
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_char   = 8'hxx;
      repeat (2) @(posedge clk);
      #1 reset  = 1'b0;
      outq.delete();
   endtask

   task automatic send(input logic [7:0] c);
      int n;
      n = 0;
      in_char  = c;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_char  = 8'hxx;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++)
         send(s[i]);
   endtask

   task automatic expect_out(input string tag, input string s);
      int n;
      n = 0;
      while (outq.size() < s.len() && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (8) @(posedge clk);
      #1;
      check({tag, "_len"}, outq.size(), s.len());
      for (int i = 0; i < s.len() && i < outq.size(); i++)
         check({tag, "_char"}, {24'd0, outq[i]}, {24'd0, s[i]});
      outq.delete();
   endtask

   initial begin
      out_ready = 1'b1;
      do_reset();

      // reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_word_count", word_count, 0);

      // single-char latency
      check("lat_pre_valid", out_valid, 0);
      send("x");
      check("lat_out_valid", out_valid, 1);
      check("lat_out_char", out_char, 8'h78);
      expect_out("lat", "x");

      // leading separators, case folding, tab/newline handling
      do_reset();
      send_str("  Begin\tEND\n");
      expect_out("basic", "begin end ");
      check("basic_wc", word_count, 2);

      // separator run collapse
      do_reset();
      send_str("a \t\r\nB!");
      expect_out("collapse", "a b!");
      check("collapse_wc", word_count, 2);

      // backpressure: fill, stall, drain in order
      do_reset();
      out_ready = 1'b0;
      send_str("abcd");
      check("full_in_ready", in_ready, 0);
      check("full_head", out_char, "a");
      fork
         begin
            send("e");
            send("f");
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      expect_out("bp", "abcdef");
      check("bp_wc", word_count, 1);

      // junk dropped, in_char ignored while idle
      do_reset();
      send("a");
      send(8'h01);
      send(8'h7F);
      send(8'hFF);
      in_char = "Q";
      repeat (3) @(posedge clk);
      #1 in_char = 8'hxx;
      send("b");
      expect_out("junk", "ab");
      check("junk_wc", word_count, 1);

      // reset mid-stream discards buffered chars
      do_reset();
      out_ready = 1'b0;
      send_str("abc");
      check("mid_out_valid_pre", out_valid, 1);
      reset = 1'b1;
      #1;
      check("mid_out_valid", out_valid, 0);
      check("mid_in_ready", in_ready, 1);
      check("mid_wc_clear", word_count, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      outq.delete();
      out_ready = 1'b1;
      send("z");
      expect_out("mid", "z");
      check("mid_wc", word_count, 1);

      // word counter saturation, preloaded near the top
      do_reset();
      force dut.wcnt_q = 16'hFFFD;
      @(posedge clk);
      #1 release dut.wcnt_q;
      check("sat_preload", word_count, 16'hFFFD);
      send_str("a ");
      check("sat_fffe", word_count, 16'hFFFE);
      send_str("b ");
      check("sat_ffff", word_count, 16'hFFFF);
      send_str("c ");
      check("sat_hold", word_count, 16'hFFFF);
      expect_out("sat", "a b c ");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
